// File: rtl/muldiv_scheduler.sv
// Sequences the shared multi-cycle mult/div unit: launches an op from execute, stalls the
// pipeline until it retires, and shares the single regfile write port with MW writeback.
module muldiv_scheduler #(
    parameter int TIMEOUT     = 40,
    parameter int STATUS_REG  = 30,
    parameter int MULT_STATUS = 4,
    parameter int DIV_STATUS  = 5
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_x_valid,
    input  logic        i_x_is_div,
    input  logic [4:0]  i_x_rd,
    output logic        o_md_ctrl_mult,
    output logic        o_md_ctrl_div,
    input  logic        i_md_ready,
    input  logic        i_md_exception,
    input  logic [31:0] i_md_result,
    input  logic        i_wb_req,
    input  logic [4:0]  i_wb_reg,
    input  logic [31:0] i_wb_data,
    output logic        o_stall,
    output logic        o_md_retire,
    output logic        o_busy,
    output logic [4:0]  o_busy_rd,
    output logic        o_rf_we,
    output logic [4:0]  o_rf_waddr,
    output logic [31:0] o_rf_wdata
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_C     = CW'(TIMEOUT);
    localparam logic [4:0]    STATUS_REG_C  = 5'(STATUS_REG);
    localparam logic [31:0]   MULT_STATUS_C = 32'(MULT_STATUS);
    localparam logic [31:0]   DIV_STATUS_C  = 32'(DIV_STATUS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_WRITE
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_next;
    logic [4:0]      r_rd;
    logic [4:0]      w_rd_next;
    logic            r_kind;
    logic            w_kind_next;
    logic [31:0]     r_result;
    logic [31:0]     w_result_next;
    logic            r_exc;
    logic            w_exc_next;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_rd     <= '0;
            r_kind   <= 1'b0;
            r_result <= '0;
            r_exc    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_count  <= w_count_next;
            r_rd     <= w_rd_next;
            r_kind   <= w_kind_next;
            r_result <= w_result_next;
            r_exc    <= w_exc_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_count_next   = r_count;
        w_rd_next      = r_rd;
        w_kind_next    = r_kind;
        w_result_next  = r_result;
        w_exc_next     = r_exc;
        o_md_ctrl_mult = 1'b0;
        o_md_ctrl_div  = 1'b0;
        o_stall        = 1'b0;
        o_md_retire    = 1'b0;
        o_rf_we        = i_wb_req;
        o_rf_waddr     = i_wb_reg;
        o_rf_wdata     = i_wb_data;

        case (r_state)
            S_IDLE: begin
                if (i_x_valid) begin
                    o_stall       = 1'b1;
                    w_rd_next     = i_x_rd;
                    w_kind_next   = i_x_is_div;
                    w_exc_next    = 1'b0;
                    w_result_next = '0;
                    w_state_next  = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                o_stall        = 1'b1;
                o_md_ctrl_div  = r_kind;
                o_md_ctrl_mult = ~r_kind;
                w_count_next   = '0;
                w_state_next   = S_RUN;
            end
            S_RUN: begin
                o_stall = 1'b1;
                if (r_count != TIMEOUT_C) begin
                    w_count_next = r_count + 1'b1;
                end
                // A result arriving on the timeout cycle still wins.
                if (i_md_ready) begin
                    w_result_next = i_md_result;
                    w_exc_next    = i_md_exception;
                    w_state_next  = S_WRITE;
                end else if (r_count == TIMEOUT_C) begin
                    w_exc_next   = 1'b1;
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                // MW writeback is older in program order, so it owns the port first.
                if (i_wb_req) begin
                    o_stall = 1'b1;
                end else begin
                    o_md_retire  = 1'b1;
                    w_state_next = S_IDLE;
                    if (r_exc) begin
                        o_rf_we    = 1'b1;
                        o_rf_waddr = STATUS_REG_C;
                        o_rf_wdata = r_kind ? DIV_STATUS_C : MULT_STATUS_C;
                    end else begin
                        o_rf_we    = (r_rd != 5'd0);
                        o_rf_waddr = r_rd;
                        o_rf_wdata = r_result;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign o_busy    = (r_state != S_IDLE);
    assign o_busy_rd = o_busy ? r_rd : 5'd0;

endmodule

// File: tb/tb_muldiv_scheduler.sv
// Directed and randomized transactions against muldiv_scheduler; expected outputs come from
// each transaction's plan (launch cycle, result delay, writeback contention) with plain arithmetic.
module tb_muldiv_scheduler;

    localparam int TO = 40;

    logic        clk;
    logic        rst_n;
    logic        x_valid;
    logic        x_is_div;
    logic [4:0]  x_rd;
    logic        md_ctrl_mult;
    logic        md_ctrl_div;
    logic        md_ready;
    logic        md_exception;
    logic [31:0] md_result;
    logic        wb_req;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        stall;
    logic        md_retire;
    logic        busy;
    logic [4:0]  busy_rd;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int checks_total  = 0;
    int checks_passed = 0;

    muldiv_scheduler dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_x_valid      (x_valid),
        .i_x_is_div     (x_is_div),
        .i_x_rd         (x_rd),
        .o_md_ctrl_mult (md_ctrl_mult),
        .o_md_ctrl_div  (md_ctrl_div),
        .i_md_ready     (md_ready),
        .i_md_exception (md_exception),
        .i_md_result    (md_result),
        .i_wb_req       (wb_req),
        .i_wb_reg       (wb_reg),
        .i_wb_data      (wb_data),
        .o_stall        (stall),
        .o_md_retire    (md_retire),
        .o_busy         (busy),
        .o_busy_rd      (busy_rd),
        .o_rf_we        (rf_we),
        .o_rf_waddr     (rf_waddr),
        .o_rf_wdata     (rf_wdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) begin
            checks_passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_outs(input string tag, input bit e_stall, input bit e_busy,
                               input logic [4:0] e_brd, input bit e_mult, input bit e_div,
                               input bit e_ret, input bit e_we, input logic [4:0] e_wa,
                               input logic [31:0] e_wd);
        chk({tag, ".stall"},   32'(stall),        32'(e_stall));
        chk({tag, ".busy"},    32'(busy),         32'(e_busy));
        chk({tag, ".busy_rd"}, 32'(busy_rd),      32'(e_brd));
        chk({tag, ".mult"},    32'(md_ctrl_mult), 32'(e_mult));
        chk({tag, ".div"},     32'(md_ctrl_div),  32'(e_div));
        chk({tag, ".retire"},  32'(md_retire),    32'(e_ret));
        chk({tag, ".rf_we"},   32'(rf_we),        32'(e_we));
        chk({tag, ".waddr"},   32'(rf_waddr),     32'(e_wa));
        chk({tag, ".wdata"},   rf_wdata,          e_wd);
    endtask

    // Apply one cycle of inputs shortly after the rising edge; outputs are checked 1ns later.
    task automatic drive(input bit xv, input bit xdiv, input logic [4:0] xrd, input bit mdr,
                         input bit mde, input logic [31:0] mres, input bit wq,
                         input logic [4:0] wr, input logic [31:0] wd);
        @(posedge clk);
        #1;
        x_valid = xv; x_is_div = xdiv; x_rd = xrd;
        md_ready = mdr; md_exception = mde; md_result = mres;
        wb_req = wq; wb_reg = wr; wb_data = wd;
        #1;
    endtask

    // d: cycles after the launch cycle that md_ready arrives (beyond TO+1 means never).
    // k: cycles of MW writeback contention once the result is in.
    task automatic run_op(input string name, input bit kind, input logic [4:0] rd, input int d,
                          input bit exc, input logic [31:0] res, input int k,
                          input logic [4:0] kreg, input logic [31:0] kdata);
        bit          wq;
        logic [4:0]  wr;
        logic [31:0] wd;
        int          n;
        bit          exc_eff;
        bit          e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        n       = (d <= TO + 1) ? d : TO + 1;
        exc_eff = (d <= TO + 1) ? exc : 1'b1;

        wq = 1'($urandom); wr = 5'($urandom); wd = $urandom;
        drive(1, kind, rd, 0, 0, $urandom, wq, wr, wd);
        expect_outs({name, ".issue"}, 1, 0, 5'd0, 0, 0, 0, wq, wr, wd);

        wq = 1'($urandom); wr = 5'($urandom); wd = $urandom;
        drive(1, kind, rd, 0, 0, $urandom, wq, wr, wd);
        expect_outs({name, ".launch"}, 1, 1, rd, !kind, kind, 0, wq, wr, wd);

        for (int j = 1; j <= n; j++) begin
            wq = 1'($urandom); wr = 5'($urandom); wd = $urandom;
            if (j == d) drive(1, kind, rd, 1, exc, res, wq, wr, wd);
            else        drive(1, kind, rd, 0, 0, $urandom, wq, wr, wd);
            expect_outs($sformatf("%s.run%0d", name, j), 1, 1, rd, 0, 0, 0, wq, wr, wd);
        end

        for (int i = 0; i < k; i++) begin
            drive(1, kind, rd, 1'($urandom), 0, $urandom, 1, kreg, kdata);
            expect_outs($sformatf("%s.wbwait%0d", name, i), 1, 1, rd, 0, 0, 0, 1, kreg, kdata);
        end

        if (exc_eff) begin
            e_we = 1; e_wa = 5'd30; e_wd = kind ? 32'd5 : 32'd4;
        end else begin
            e_we = (rd != 5'd0); e_wa = rd; e_wd = res;
        end
        drive(1, kind, rd, 0, 0, $urandom, 0, 5'($urandom), $urandom);
        expect_outs({name, ".retire"}, 0, 1, rd, 0, 0, 1, e_we, e_wa, e_wd);

        // Pipeline squashed the retiring op: no relaunch, stray md_ready ignored.
        wq = 1'($urandom); wr = 5'($urandom); wd = $urandom;
        drive(0, 1'($urandom), 5'($urandom), 1'($urandom), 0, $urandom, wq, wr, wd);
        expect_outs({name, ".idle"}, 0, 0, 5'd0, 0, 0, 0, wq, wr, wd);

        $display("op %s: kind=%s rd=%0d delay=%0d exc=%0d wbwait=%0d -> write r%0d=%0h we=%0d",
                 name, kind ? "div" : "mult", rd, d, exc_eff, k, e_wa, e_wd, e_we);
    endtask

    initial begin
        rst_n = 1'b0;
        x_valid = 0; x_is_div = 0; x_rd = '0;
        md_ready = 0; md_exception = 0; md_result = '0;
        wb_req = 1; wb_reg = 5'd11; wb_data = 32'hdead_beef;
        #2;
        expect_outs("reset", 0, 0, 5'd0, 0, 0, 0, 1, 5'd11, 32'hdead_beef);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        $display("reset released");

        run_op("t1_mult", 0, 5'd3, 3, 0, 32'd42, 0, 5'd0, 32'd0);
        run_op("t2_divexc", 1, 5'd7, 4, 1, 32'h1234, 0, 5'd0, 32'd0);
        run_op("t3_wbprio", 0, 5'd12, 2, 0, 32'hcafe_f00d, 2, 5'd4, 32'd9);
        run_op("t4_r0", 0, 5'd0, 1, 0, 32'd99, 0, 5'd0, 32'd0);
        run_op("t5_timeout", 1, 5'd9, 1000, 0, 32'd0, 0, 5'd0, 32'd0);
        run_op("t5b_readyattimeout", 0, 5'd17, TO + 1, 0, 32'h77, 1, 5'd2, 32'd3);

        for (int r = 0; r < 16; r++) begin
            run_op($sformatf("rnd%0d", r), 1'($urandom),
                   ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
                   int'($urandom_range(1, 45)), ($urandom_range(0, 3) == 0),
                   $urandom, int'($urandom_range(0, 3)), 5'($urandom), $urandom);
        end

        // Reset in the middle of RUN discards the op.
        drive(1, 1, 5'd21, 0, 0, 0, 0, 5'd0, 32'd0);
        drive(1, 1, 5'd21, 0, 0, 0, 0, 5'd0, 32'd0);
        chk("t6.launch_div", 32'(md_ctrl_div), 32'd1);
        for (int j = 0; j < 5; j++) drive(1, 1, 5'd21, 0, 0, 0, 0, 5'd0, 32'd0);
        chk("t6.busy_before", 32'(busy), 32'd1);
        x_valid = 0;
        rst_n   = 1'b0;
        #1;
        expect_outs("t6.inreset", 0, 0, 5'd0, 0, 0, 0, 0, 5'd0, 32'd0);
        drive(0, 0, 5'd0, 1, 0, 32'h55, 1, 5'd6, 32'h66);
        expect_outs("t6.inreset2", 0, 0, 5'd0, 0, 0, 0, 1, 5'd6, 32'h66);
        rst_n = 1'b1;
        drive(0, 0, 5'd0, 1, 0, 32'h55, 0, 5'd8, 32'h88);
        expect_outs("t6.stray_ready", 0, 0, 5'd0, 0, 0, 0, 0, 5'd8, 32'h88);
        drive(0, 0, 5'd0, 0, 0, 32'h0, 0, 5'd8, 32'h88);
        expect_outs("t6.no_relaunch", 0, 0, 5'd0, 0, 0, 0, 0, 5'd8, 32'h88);
        $display("op t6_reset: reset mid-RUN, stray md_ready ignored");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
